// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared state encoding, default bit period and the 2-of-3 vote used by the UART receiver.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 50;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_sync.sv
`timescale 1ns/1ps
// Two-flop synchroniser, one chain per bit, reset to the idle-high line level.
module rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/uart_rx_deframer.sv
`timescale 1ns/1ps
// UART 8-bit receiver: start validation, 3-sample majority, framing/break detection.
// Optional parity check compiled in with `define UART_RX_PARITY_EN.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       rxReady,
  output logic [7:0] rxData,
  output logic       rxBusy,
  output logic       frameError,
  output logic       breakDetect,
  output logic       parityError
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int M  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_SMP0  = CW'(M - 1);
  localparam logic [CW-1:0] CNT_SMP1  = CW'(M);
  localparam logic [CW-1:0] CNT_DEC   = CW'(M + 1);

  logic rx_s;

  rx_sync #(
    .WIDTH(1)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (rx),
    .q      (rx_s)
  );

  rx_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [1:0]    samp_reg, samp_next;
  logic [7:0]    shreg_reg, shreg_next;
  logic [7:0]    data_reg, data_next;
  logic          ready_reg, ready_next;
  logic          ferr_reg, ferr_next;
  logic          brk_reg, brk_next;

  logic bit_end;
  logic at_decide;
  logic maj;

  assign bit_end   = (cnt_reg == CNT_LAST);
  assign at_decide = (cnt_reg == CNT_DEC);
  // Third vote is the live sample, so every decision lands on cnt == M+1.
  assign maj       = majority3(samp_reg[0], samp_reg[1], rx_s);

`ifdef UART_RX_PARITY_EN
  logic par_bit_reg, par_bit_next;
  logic perr_reg, perr_next;
  logic parity_bad;

  assign parity_bad = (((^shreg_reg) ^ par_bit_reg) != PARITY_ODD);
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = bit_end ? '0 : cnt_reg + 1'b1;
    idx_next   = idx_reg;
    samp_next  = samp_reg;
    shreg_next = shreg_reg;
    data_next  = data_reg;
    ready_next = 1'b0;
    ferr_next  = 1'b0;
    brk_next   = brk_reg;
`ifdef UART_RX_PARITY_EN
    par_bit_next = par_bit_reg;
    perr_next    = 1'b0;
`endif

    if (cnt_reg == CNT_SMP0) samp_next[0] = rx_s;
    if (cnt_reg == CNT_SMP1) samp_next[1] = rx_s;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end

      START: begin
        if (at_decide && maj) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (bit_end) begin
          state_next = DATA;
          idx_next   = 3'd0;
        end
      end

      DATA: begin
        if (at_decide) shreg_next = {maj, shreg_reg[7:1]};
        if (bit_end) begin
          if (idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_decide) par_bit_next = maj;
        if (bit_end) state_next = STOP;
      end
`endif

      // Decide half a bit early so a back-to-back start edge is caught from IDLE.
      STOP: begin
        if (at_decide) begin
          cnt_next = '0;
          if (maj) begin
            state_next = IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_bad) begin
              perr_next = 1'b1;
            end else begin
              data_next  = shreg_reg;
              ready_next = 1'b1;
            end
`else
            data_next  = shreg_reg;
            ready_next = 1'b1;
`endif
          end else begin
            ferr_next = 1'b1;
            if (shreg_reg == 8'h00) begin
              brk_next   = 1'b1;
              state_next = BREAK;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end

      BREAK: begin
        cnt_next = '0;
        if (rx_s) begin
          brk_next   = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      samp_reg  <= '0;
      shreg_reg <= '0;
      data_reg  <= '0;
      ready_reg <= 1'b0;
      ferr_reg  <= 1'b0;
      brk_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      samp_reg  <= samp_next;
      shreg_reg <= shreg_next;
      data_reg  <= data_next;
      ready_reg <= ready_next;
      ferr_reg  <= ferr_next;
      brk_reg   <= brk_next;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_bit_reg <= 1'b0;
      perr_reg    <= 1'b0;
    end else begin
      par_bit_reg <= par_bit_next;
      perr_reg    <= perr_next;
    end
  end

  assign parityError = perr_reg;
`else
  logic unused_parity_odd;

  assign unused_parity_odd = PARITY_ODD;
  assign parityError       = 1'b0;
`endif

  assign rxReady     = ready_reg;
  assign rxData      = data_reg;
  assign rxBusy      = (state_reg != IDLE);
  assign frameError  = ferr_reg;
  assign breakDetect = brk_reg;

endmodule

// File: tb/tb_uart_rx_deframer.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_deframer at 16 clocks per bit (10 ns clock, 160 ns bit).
module tb_uart_rx_deframer;

  localparam int  C      = 16;
  localparam int  M      = C / 2;
  localparam real BIT_NS = 160.0;
`ifdef UART_RX_PARITY_EN
  localparam int  LAT    = 10 * C + M + 4;
`else
  localparam int  LAT    = 9 * C + M + 4;
`endif

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx      = 1'b1;
  logic       rxReady;
  logic [7:0] rxData;
  logic       rxBusy;
  logic       frameError;
  logic       breakDetect;
  logic       parityError;

  int errors = 0;
  int checks = 0;

  uart_rx_deframer #(
    .CLKS_PER_BIT(C),
    .PARITY_ODD  (1'b0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .rxReady    (rxReady),
    .rxData     (rxData),
    .rxBusy     (rxBusy),
    .frameError (frameError),
    .breakDetect(breakDetect),
    .parityError(parityError)
  );

  always #5 clk = ~clk;

  // Posedge counter: at a negedge, cyc is the index of the edge just taken.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         ready_cnt = 0;
  int         fe_cnt    = 0;
  int         pe_cnt    = 0;
  int         busy_cycles = 0;
  int         ready_cyc = 0;
  logic [7:0] data_log [0:63];
  logic       busy_at_ready = 1'b0;
  logic       busy_before_ready = 1'b0;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rxReady) begin
      data_log[ready_cnt[5:0]] = rxData;
      ready_cnt = ready_cnt + 1;
      ready_cyc = cyc;
      busy_at_ready = rxBusy;
      busy_before_ready = busy_prev;
      $display("rx byte 0x%02h at cycle %0d", rxData, cyc);
    end
    if (frameError) begin
      fe_cnt = fe_cnt + 1;
      $display("frame error pulse at cycle %0d", cyc);
    end
    if (parityError) begin
      pe_cnt = pe_cnt + 1;
      $display("parity error pulse at cycle %0d", cyc);
    end
    if (rxBusy) busy_cycles = busy_cycles + 1;
    busy_prev = rxBusy;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic send_bit(input logic b, input real bit_ns);
    rx = b;
    #(bit_ns);
  endtask

  // Start, 8 data LSB first, even parity when compiled in, stop; line left idle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input real bit_ns);
    send_bit(1'b0, bit_ns);
    for (int i = 0; i < 8; i++) send_bit(d[i], bit_ns);
`ifdef UART_RX_PARITY_EN
    send_bit(^d, bit_ns);
`endif
    send_bit(stop, bit_ns);
    rx = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (rxReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", rxReady); end
    checks++; if (rxData !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rxData); end
    checks++; if (rxBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rxBusy); end
    checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frameError); end
    checks++; if (breakDetect !== 1'b0) begin errors++; $display("FAIL reset_break: got %b expected 0", breakDetect); end
    checks++; if (parityError !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", parityError); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycles(2 * C);
    checks++; if (rxBusy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", rxBusy); end
  endtask

  task automatic test_single_byte;
    int base_r, base_f, t0;
    base_r = ready_cnt;
    base_f = fe_cnt;
    @(posedge clk); #1;
    t0 = cyc + 1;
    send_frame(8'h0A, 1'b1, BIT_NS);
    idle_cycles(C);
    checks++; if (ready_cnt - base_r !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", ready_cnt - base_r); end
    checks++; if (ready_cyc - t0 !== LAT) begin errors++; $display("FAIL single_latency: got %0d expected %0d", ready_cyc - t0, LAT); end
    checks++; if (data_log[base_r[5:0]] !== 8'h0A) begin errors++; $display("FAIL single_data: got %h expected 0a", data_log[base_r[5:0]]); end
    checks++; if (rxData !== 8'h0A) begin errors++; $display("FAIL single_hold: got %h expected 0a", rxData); end
    checks++; if (fe_cnt - base_f !== 0) begin errors++; $display("FAIL single_ferr: got %0d expected 0", fe_cnt - base_f); end
    checks++; if ({busy_before_ready, busy_at_ready} !== 2'b10) begin errors++; $display("FAIL single_busy_edge: got %b expected 10", {busy_before_ready, busy_at_ready}); end
  endtask

  task automatic test_false_start;
    int base_r, base_f;
    base_r = ready_cnt;
    base_f = fe_cnt;
    busy_cycles = 0;
    @(posedge clk); #1;
    rx = 1'b0;
    @(posedge clk); #1;
    rx = 1'b1;
    idle_cycles(3 * C);
    checks++; if (busy_cycles !== M + 2) begin errors++; $display("FAIL false_busy_len: got %0d expected %0d", busy_cycles, M + 2); end
    checks++; if (ready_cnt - base_r !== 0) begin errors++; $display("FAIL false_ready: got %0d expected 0", ready_cnt - base_r); end
    checks++; if (fe_cnt - base_f !== 0) begin errors++; $display("FAIL false_ferr: got %0d expected 0", fe_cnt - base_f); end
  endtask

  task automatic test_frame_error;
    int base_r, base_f;
    base_r = ready_cnt;
    base_f = fe_cnt;
    @(posedge clk); #1;
    send_frame(8'h55, 1'b0, BIT_NS);
    idle_cycles(3 * C);
    checks++; if (fe_cnt - base_f !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt - base_f); end
    checks++; if (ready_cnt - base_r !== 0) begin errors++; $display("FAIL ferr_ready: got %0d expected 0", ready_cnt - base_r); end
    checks++; if (rxData !== 8'h0A) begin errors++; $display("FAIL ferr_data_hold: got %h expected 0a", rxData); end
    checks++; if (breakDetect !== 1'b0) begin errors++; $display("FAIL ferr_break: got %b expected 0", breakDetect); end
  endtask

  task automatic test_break;
    int base_r, base_f;
    base_r = ready_cnt;
    base_f = fe_cnt;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (151) @(posedge clk);
    @(negedge clk);
    checks++; if (breakDetect !== 1'b0) begin errors++; $display("FAIL break_early: got %b expected 0", breakDetect); end
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++; if (breakDetect !== 1'b1) begin errors++; $display("FAIL break_level: got %b expected 1", breakDetect); end
    repeat (20 * C - 201) @(posedge clk);
    @(negedge clk);
    checks++; if (breakDetect !== 1'b1) begin errors++; $display("FAIL break_hold: got %b expected 1", breakDetect); end
    checks++; if (fe_cnt - base_f !== 1) begin errors++; $display("FAIL break_ferr_count: got %0d expected 1", fe_cnt - base_f); end
    @(posedge clk); #1;
    rx = 1'b1;
    idle_cycles(5);
    checks++; if (breakDetect !== 1'b0) begin errors++; $display("FAIL break_clear: got %b expected 0", breakDetect); end
    checks++; if (rxBusy !== 1'b0) begin errors++; $display("FAIL break_idle: got %b expected 0", rxBusy); end
    idle_cycles(C);
    send_frame(8'h3C, 1'b1, BIT_NS);
    idle_cycles(C);
    checks++; if (ready_cnt - base_r !== 1) begin errors++; $display("FAIL break_after_count: got %0d expected 1", ready_cnt - base_r); end
    checks++; if (rxData !== 8'h3C) begin errors++; $display("FAIL break_after_data: got %h expected 3c", rxData); end
  endtask

  task automatic test_back_to_back;
    real rates [3];
    int  base_r, base_f;
    rates[0] = BIT_NS;
    rates[1] = BIT_NS * 0.97;
    rates[2] = BIT_NS * 1.03;
    for (int r = 0; r < 3; r++) begin
      base_r = ready_cnt;
      base_f = fe_cnt;
      send_frame(8'h01, 1'b1, rates[r]);
      send_frame(8'h12, 1'b1, rates[r]);
      idle_cycles(2 * C);
      checks++; if (ready_cnt - base_r !== 2) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 2", r, ready_cnt - base_r); end
      checks++; if (data_log[base_r[5:0]] !== 8'h01) begin errors++; $display("FAIL b2b_first[%0d]: got %h expected 01", r, data_log[base_r[5:0]]); end
      checks++; if (data_log[6'(base_r + 1)] !== 8'h12) begin errors++; $display("FAIL b2b_second[%0d]: got %h expected 12", r, data_log[6'(base_r + 1)]); end
      checks++; if (fe_cnt - base_f !== 0) begin errors++; $display("FAIL b2b_ferr[%0d]: got %0d expected 0", r, fe_cnt - base_f); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int base_r;
    base_r = ready_cnt;
    @(posedge clk); #1;
    send_bit(1'b0, BIT_NS);
    for (int i = 0; i < 4; i++) send_bit(1'b1, BIT_NS);
    rx = 1'b1;
    #(BIT_NS / 2.0);
    reset_n = 1'b0;
    #1;
    checks++; if (rxBusy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", rxBusy); end
    checks++; if (rxData !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h expected 00", rxData); end
    checks++; if ({rxReady, frameError, breakDetect, parityError} !== 4'b0000) begin errors++; $display("FAIL rst_mid_pulses: got %b expected 0000", {rxReady, frameError, breakDetect, parityError}); end
    idle_cycles(3);
    reset_n = 1'b1;
    idle_cycles(6 * C);
    checks++; if (ready_cnt - base_r !== 0) begin errors++; $display("FAIL rst_mid_discard: got %0d expected 0", ready_cnt - base_r); end
    send_frame(8'h11, 1'b1, BIT_NS);
    idle_cycles(C);
    checks++; if (ready_cnt - base_r !== 1) begin errors++; $display("FAIL rst_after_count: got %0d expected 1", ready_cnt - base_r); end
    checks++; if (rxData !== 8'h11) begin errors++; $display("FAIL rst_after_data: got %h expected 11", rxData); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0, BIT_NS);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT_NS);
    send_bit(par, BIT_NS);
    send_bit(1'b1, BIT_NS);
    rx = 1'b1;
  endtask

  task automatic test_parity;
    int base_r, base_p;
    logic [7:0] held;
    held = rxData;
    base_r = ready_cnt;
    base_p = pe_cnt;
    send_frame_par(8'hA5, 1'b1);
    idle_cycles(C);
    checks++; if (pe_cnt - base_p !== 1) begin errors++; $display("FAIL par_bad_pulse: got %0d expected 1", pe_cnt - base_p); end
    checks++; if (ready_cnt - base_r !== 0) begin errors++; $display("FAIL par_bad_ready: got %0d expected 0", ready_cnt - base_r); end
    checks++; if (rxData !== held) begin errors++; $display("FAIL par_bad_hold: got %h expected %h", rxData, held); end
    send_frame_par(8'hA5, 1'b0);
    idle_cycles(C);
    checks++; if (pe_cnt - base_p !== 1) begin errors++; $display("FAIL par_good_pulse: got %0d expected 1", pe_cnt - base_p); end
    checks++; if (ready_cnt - base_r !== 1) begin errors++; $display("FAIL par_good_ready: got %0d expected 1", ready_cnt - base_r); end
    checks++; if (rxData !== 8'hA5) begin errors++; $display("FAIL par_good_data: got %h expected a5", rxData); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_false_start();
    test_frame_error();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
